// File: rtl/sel_scan_pkg.sv
// Shared types and constants for the selector scan controller.
// The state enum is used by the top-level FSM; channel sizing is used by every file.
package sel_scan_pkg;

  localparam int NCH  = 4;
  localparam int CH_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sel_next_ch.sv
// Picks the next enabled channel strictly above the current one.
// When i_first is set, the current channel is treated as -1, so the lowest enabled channel is returned.
module sel_next_ch
  import sel_scan_pkg::*;
(
  input  logic [NCH-1:0]  i_mask,
  input  logic [CH_W-1:0] i_cur,
  input  logic            i_first,
  output logic [CH_W-1:0] o_next,
  output logic            o_found
);

  // The loop runs downward so that the lowest qualifying index is written last and wins.
  always_comb begin
    o_next  = '0;
    o_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_next  = CH_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_scan_ctrl.sv
// Sequencer for a 4:1 selector: dwells on each enabled channel, samples the selector output,
// and publishes one capture per channel plus a per-channel snapshot and a sweep-done pulse.
module sel_scan_ctrl
  import sel_scan_pkg::*;
#(
  parameter int DW      = 2,
  parameter int DWELL_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_cont,
  input  logic [NCH-1:0]     i_en_mask,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [DW-1:0]      i_mux_in,
  output logic [CH_W-1:0]    o_sel_out,
  output logic               o_busy,
  output logic               o_cap_valid,
  output logic [CH_W-1:0]    o_cap_ch,
  output logic [DW-1:0]      o_cap_data,
  output logic [NCH*DW-1:0]  o_snap,
  output logic               o_frame_done
);

  state_t               r_state;
  logic [DWELL_W-1:0]   r_cnt;
  logic [NCH-1:0]       r_mask;
  logic [DWELL_W-1:0]   r_dwell;
  logic [CH_W-1:0]      r_sel;
  logic                 r_busy;
  logic                 r_cap_valid;
  logic [CH_W-1:0]      r_cap_ch;
  logic [DW-1:0]        r_cap_data;
  logic [NCH*DW-1:0]    r_snap;
  logic                 r_frame_done;

  logic [CH_W-1:0]      w_next_ch;
  logic                 w_next_found;
  logic [CH_W-1:0]      w_first_ch;
  logic                 w_first_found;
  logic [DWELL_W-1:0]   w_dwell_last;

  sel_next_ch u_next (
    .i_mask  (r_mask),
    .i_cur   (r_sel),
    .i_first (1'b0),
    .o_next  (w_next_ch),
    .o_found (w_next_found)
  );

  // The first-channel search looks at the live mask because it is only used at latch points.
  sel_next_ch u_first (
    .i_mask  (i_en_mask),
    .i_cur   (r_sel),
    .i_first (1'b1),
    .o_next  (w_first_ch),
    .o_found (w_first_found)
  );

  assign w_dwell_last = (r_dwell == '0) ? '0 : (r_dwell - 1'b1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_dwell      <= '0;
      r_sel        <= '0;
      r_busy       <= 1'b0;
      r_cap_valid  <= 1'b0;
      r_cap_ch     <= '0;
      r_cap_data   <= '0;
      r_snap       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cap_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && w_first_found) begin
            r_mask  <= i_en_mask;
            r_dwell <= i_dwell;
            r_sel   <= w_first_ch;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_cnt == w_dwell_last) begin
            r_cap_valid             <= 1'b1;
            r_cap_ch                <= r_sel;
            r_cap_data              <= i_mux_in;
            r_snap[r_sel*DW +: DW]  <= i_mux_in;
            if (w_next_found) begin
              r_sel <= w_next_ch;
              r_cnt <= '0;
            end else begin
              r_state <= DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_frame_done <= 1'b1;
          if (i_cont && w_first_found) begin
            r_mask  <= i_en_mask;
            r_dwell <= i_dwell;
            r_sel   <= w_first_ch;
            r_cnt   <= '0;
            r_state <= SCAN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_sel_out    = r_sel;
  assign o_busy       = r_busy;
  assign o_cap_valid  = r_cap_valid;
  assign o_cap_ch     = r_cap_ch;
  assign o_cap_data   = r_cap_data;
  assign o_snap       = r_snap;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Self-checking bench for sel_scan_ctrl; the 4:1 selector is modelled as a lookup on chData.
// Expected sweep timelines are computed from channel list, dwell and sweep position arithmetic.
module tb_sel_scan_ctrl;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       cont;
  logic [3:0] enMask;
  logic [3:0] dwell;
  logic [1:0] muxIn;
  logic [1:0] selOut;
  logic       busy;
  logic       capValid;
  logic [1:0] capCh;
  logic [1:0] capData;
  logic [7:0] snap;
  logic       frameDone;

  logic [1:0] chData [4];
  logic [7:0] modelSnap;
  int         nChecks;
  int         nFails;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] dwell;
    int         expFrameAt;
    int         expCaps;
    logic [7:0] expSnap;
  } vec_t;

  vec_t vecs [5];

  sel_scan_ctrl #(.DW(2), .DWELL_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_start      (start),
    .i_cont       (cont),
    .i_en_mask    (enMask),
    .i_dwell      (dwell),
    .i_mux_in     (muxIn),
    .o_sel_out    (selOut),
    .o_busy       (busy),
    .o_cap_valid  (capValid),
    .o_cap_ch     (capCh),
    .o_cap_data   (capData),
    .o_snap       (snap),
    .o_frame_done (frameDone)
  );

  // Selector stand-in: static channel data routed by the controller's select.
  always_comb muxIn = chData[selOut];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drives the sweep configuration with a one-cycle start pulse; returns #1 into cycle 1.
  task automatic applyStimulus(input logic [3:0] m, input logic [3:0] d, input logic c);
    enMask = m;
    dwell  = d;
    cont   = c;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic runSweep(input logic [3:0] mask, input logic [3:0] dw, input bit scramble,
                          output int frameAt, output int nCap);
    int chList[$];
    int n;
    int d;
    int lastT;
    int k;
    int j;
    logic expCv;
    chList = {};
    for (int i = 0; i < 4; i++) if (mask[i]) chList.push_back(i);
    n = chList.size();
    d = (dw == 4'd0) ? 1 : int'(dw);
    lastT = n * d + 3;
    frameAt = -1;
    nCap = 0;
    applyStimulus(mask, dw, 1'b0);
    for (int t = 1; t <= lastT; t++) begin
      if (t > 1) begin
        @(posedge clk);
        #1;
      end
      k = (t - 1) / d;
      if (k > n - 1) k = n - 1;
      j = (t - 1) / d;
      expCv = ((t - 1) % d == 0) && (j >= 1) && (j <= n);
      checkOutput("sel", 32'(selOut), 32'(chList[k]));
      checkOutput("busy", 32'(busy), 32'(t <= n * d + 1));
      checkOutput("capValid", 32'(capValid), 32'(expCv));
      checkOutput("frameDone", 32'(frameDone), 32'(t == n * d + 2));
      if (expCv) begin
        checkOutput("capCh", 32'(capCh), 32'(chList[j-1]));
        checkOutput("capData", 32'(capData), 32'(chData[chList[j-1]]));
        modelSnap[chList[j-1]*2 +: 2] = chData[chList[j-1]];
      end
      if (capValid) nCap++;
      if (frameDone && frameAt < 0) frameAt = t;
      if (scramble && t <= n * d + 1) begin
        start  = 1'($urandom);
        enMask = 4'($urandom);
        dwell  = 4'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start  = 1'b0;
    enMask = mask;
    dwell  = dw;
    checkOutput("snapModel", 32'(snap), 32'(modelSnap));
  endtask

  initial begin
    int frameAt;
    int nCap;
    int extra;
    int extraAt;
    bit found;
    logic [3:0] m;
    logic [3:0] d;
    nChecks = 0;
    nFails  = 0;
    rstN    = 1'b0;
    start   = 1'b0;
    cont    = 1'b0;
    enMask  = 4'h0;
    dwell   = 4'h0;
    modelSnap = 8'h00;
    for (int i = 0; i < 4; i++) chData[i] = 2'(i);

    vecs[0] = '{mask: 4'hF, dwell: 4'd2,  expFrameAt: 10, expCaps: 4, expSnap: 8'hE4};
    vecs[1] = '{mask: 4'hA, dwell: 4'd0,  expFrameAt: 4,  expCaps: 2, expSnap: 8'hE4};
    vecs[2] = '{mask: 4'h8, dwell: 4'd5,  expFrameAt: 7,  expCaps: 1, expSnap: 8'hE4};
    vecs[3] = '{mask: 4'h6, dwell: 4'd1,  expFrameAt: 4,  expCaps: 2, expSnap: 8'hE4};
    vecs[4] = '{mask: 4'h1, dwell: 4'd15, expFrameAt: 17, expCaps: 1, expSnap: 8'hE4};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstSel", 32'(selOut), 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstCapValid", 32'(capValid), 0);
    checkOutput("rstSnap", 32'(snap), 0);
    checkOutput("rstFrame", 32'(frameDone), 0);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Directed table of sweeps over static channel data.
    for (int v = 0; v < 5; v++) begin
      runSweep(vecs[v].mask, vecs[v].dwell, 1'b0, frameAt, nCap);
      checkOutput("tblFrameAt", 32'(frameAt), 32'(vecs[v].expFrameAt));
      checkOutput("tblCaps", 32'(nCap), 32'(vecs[v].expCaps));
      checkOutput("tblSnap", 32'(snap), 32'(vecs[v].expSnap));
    end

    // Empty mask: start must be ignored entirely.
    applyStimulus(4'h0, 4'd2, 1'b0);
    for (int t = 1; t <= 20; t++) begin
      if (t > 1) begin
        @(posedge clk);
        #1;
      end
      checkOutput("emptyBusy", 32'(busy), 0);
      checkOutput("emptyCapValid", 32'(capValid), 0);
      checkOutput("emptyFrame", 32'(frameDone), 0);
    end

    // Continuous mode on a single channel, then drop cont for exactly one more sweep.
    applyStimulus(4'h1, 4'd3, 1'b1);
    for (int t = 1; t <= 17; t++) begin
      if (t > 1) begin
        @(posedge clk);
        #1;
      end
      checkOutput("contFrame", 32'(frameDone), 32'(t >= 5 && (t - 5) % 4 == 0));
      checkOutput("contBusy", 32'(busy), 1);
    end
    cont = 1'b0;
    extra = 0;
    extraAt = -1;
    for (int t = 18; t <= 40; t++) begin
      @(posedge clk);
      #1;
      if (frameDone) begin
        extra++;
        extraAt = t;
      end
    end
    checkOutput("contExtraFrames", 32'(extra), 1);
    checkOutput("contExtraAt", 32'(extraAt), 21);
    checkOutput("contIdleBusy", 32'(busy), 0);

    // Random data and configs, with start/mask/dwell churn while the sweep runs.
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 4; i++) chData[i] = 2'($urandom);
      m = 4'($urandom_range(1, 15));
      d = 4'($urandom_range(0, 6));
      runSweep(m, d, 1'b1, frameAt, nCap);
      checkOutput("rndCaps", 32'(nCap), 32'($countones(m)));
      checkOutput("rndFrameAt", 32'(frameAt), 32'($countones(m) * ((d == 0) ? 1 : int'(d)) + 2));
    end

    // Asynchronous reset while dwelling on channel 2.
    for (int i = 0; i < 4; i++) chData[i] = 2'(i);
    applyStimulus(4'hF, 4'd2, 1'b0);
    found = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      if (selOut == 2'd2) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("rstReachCh2", 32'(found), 1);
    rstN = 1'b0;
    #1;
    checkOutput("midRstSel", 32'(selOut), 0);
    checkOutput("midRstBusy", 32'(busy), 0);
    checkOutput("midRstCapValid", 32'(capValid), 0);
    checkOutput("midRstCapCh", 32'(capCh), 0);
    checkOutput("midRstCapData", 32'(capData), 0);
    checkOutput("midRstSnap", 32'(snap), 0);
    checkOutput("midRstFrame", 32'(frameDone), 0);
    modelSnap = 8'h00;
    @(posedge clk);
    #1;
    rstN = 1'b1;
    @(posedge clk);
    #1;
    runSweep(4'hF, 4'd2, 1'b0, frameAt, nCap);
    checkOutput("postRstFrameAt", 32'(frameAt), 10);
    checkOutput("postRstCaps", 32'(nCap), 4);
    checkOutput("postRstSnap", 32'(snap), 32'h0000_00E4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
